// File: rtl/lenet_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler, the camera core and the LeNet engine.
interface lenet_frame_scheduler_if #(
  parameter int unsigned RESULT_W = 4
);
  logic                frame_start;
  logic                data_ready;
  logic                trigger;
  logic                auto_en;
  logic                lenet_done;
  logic [RESULT_W-1:0] lenet_digit;
  logic                lenet_signal;
  logic                lenet_start;
  logic [RESULT_W-1:0] result;
  logic                result_valid;
  logic                busy;
  logic                timeout_err;

  // Scheduler side.
  modport master (
    input  frame_start, data_ready, trigger, auto_en, lenet_done, lenet_digit,
    output lenet_signal, lenet_start, result, result_valid, busy, timeout_err
  );

  // Core / engine / user side.
  modport slave (
    output frame_start, data_ready, trigger, auto_en, lenet_done, lenet_digit,
    input  lenet_signal, lenet_start, result, result_valid, busy, timeout_err
  );
endinterface

// File: rtl/lenet_frame_scheduler.sv
// Capture-to-inference sequencer: requests a downsampled frame, starts LeNet, latches the digit.
// Optional inference watchdog enabled by defining LENET_TIMEOUT_EN.
module lenet_frame_scheduler #(
  parameter int unsigned FRAME_INTERVAL = 4,
`ifdef LENET_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
`endif
  parameter int unsigned RESULT_W       = 4
) (
  input  logic                   clk25_i,
  input  logic                   rst_ni,
  lenet_frame_scheduler_if.master ctrl_io
);

  localparam int unsigned FcntW = $clog2(FRAME_INTERVAL + 1);
  localparam logic [FcntW-1:0] FiVal = FcntW'(FRAME_INTERVAL);

  typedef enum logic [2:0] {StIdle, StArm, StCapture, StInfer, StHold} state_e;

  state_e              state_q, state_d;
  logic                trig_d1_q, trig_rise_q;
  logic                pending_q, pending_d;
  logic [FcntW-1:0]    fcnt_q, fcnt_d, fcnt_inc;
  logic                lenet_signal_q, lenet_signal_d;
  logic                lenet_start_q, lenet_start_d;
  logic                busy_q, busy_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                done_ok, timeout_hit;

  // Completion is not accepted in the cycle the engine is being started.
  assign done_ok  = ctrl_io.lenet_done && !lenet_start_q;
  assign fcnt_inc = (fcnt_q == FiVal) ? fcnt_q : fcnt_q + 1'b1;

`ifdef LENET_TIMEOUT_EN
  localparam int unsigned TcntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             timeout_err_q;

  assign tcnt_d      = (state_q == StInfer) ? tcnt_q + 1'b1 : '0;
  assign timeout_hit = (state_q == StInfer) && !done_ok &&
                       (tcnt_q == TcntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk25_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tcnt_q        <= tcnt_d;
      timeout_err_q <= timeout_err_q | timeout_hit;
    end
  end

  assign ctrl_io.timeout_err = timeout_err_q;
`else
  assign timeout_hit         = 1'b0;
  assign ctrl_io.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    fcnt_d         = fcnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    lenet_start_d  = 1'b0;

    if (state_q != StIdle && trig_rise_q) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (trig_rise_q || pending_q || ctrl_io.auto_en) state_d = StArm;
      end
      StArm: begin
        if (ctrl_io.frame_start) state_d = StCapture;
      end
      StCapture: begin
        // data_ready wins over a coincident frame_start; a bare frame_start retries.
        if (ctrl_io.data_ready) begin
          state_d       = StInfer;
          lenet_start_d = 1'b1;
        end
      end
      StInfer: begin
        if (done_ok) begin
          result_d       = ctrl_io.lenet_digit;
          result_valid_d = 1'b1;
          fcnt_d         = '0;
          state_d        = StHold;
        end else if (timeout_hit) begin
          fcnt_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (ctrl_io.frame_start) begin
          fcnt_d = fcnt_inc;
          if (fcnt_inc == FiVal) state_d = (ctrl_io.auto_en || pending_q) ? StArm : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StArm && state_q != StArm) pending_d = 1'b0;

    lenet_signal_d = (state_d == StArm) || (state_d == StCapture);
    busy_d         = lenet_signal_d || (state_d == StInfer);
  end

  always_ff @(posedge clk25_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      trig_d1_q      <= 1'b0;
      trig_rise_q    <= 1'b0;
      pending_q      <= 1'b0;
      fcnt_q         <= '0;
      lenet_signal_q <= 1'b0;
      lenet_start_q  <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      trig_d1_q      <= ctrl_io.trigger;
      trig_rise_q    <= ctrl_io.trigger && !trig_d1_q;
      pending_q      <= pending_d;
      fcnt_q         <= fcnt_d;
      lenet_signal_q <= lenet_signal_d;
      lenet_start_q  <= lenet_start_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign ctrl_io.lenet_signal = lenet_signal_q;
  assign ctrl_io.lenet_start  = lenet_start_q;
  assign ctrl_io.busy         = busy_q;
  assign ctrl_io.result       = result_q;
  assign ctrl_io.result_valid = result_valid_q;

endmodule

// File: tb/tb_lenet_frame_scheduler.sv
// Directed bench for lenet_frame_scheduler with hand-computed expectations.
module tb_lenet_frame_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   start_cnt = 0;
  int   s0;

  always #20 clk = ~clk;

  lenet_frame_scheduler_if #(.RESULT_W(4)) bus ();

  lenet_frame_scheduler #(
    .FRAME_INTERVAL(4),
`ifdef LENET_TIMEOUT_EN
    .TIMEOUT_CYCLES(100),
`endif
    .RESULT_W(4)
  ) dut (
    .clk25_i(clk),
    .rst_ni (rst_n),
    .ctrl_io(bus)
  );

  always @(posedge clk) if (bus.lenet_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1; cyc(1); bus.frame_start = 1'b0;
  endtask

  task automatic ready_pulse();
    bus.data_ready = 1'b1; cyc(1); bus.data_ready = 1'b0;
  endtask

  task automatic trig_edge();
    bus.trigger = 1'b1; cyc(1); bus.trigger = 1'b0; cyc(1);
  endtask

  task automatic done_pulse(input logic [3:0] d);
    bus.lenet_done = 1'b1; bus.lenet_digit = d; cyc(1); bus.lenet_done = 1'b0;
  endtask

  task automatic hold_frames();
    repeat (4) begin frame_pulse(); cyc(3); end
  endtask

  task automatic test_reset();
    cyc(3);
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL rst_signal: got %b want 0", bus.lenet_signal); end
    n_vec++; if (bus.lenet_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", bus.lenet_start); end
    n_vec++; if (bus.result !== 4'd0) begin n_err++; $display("FAIL rst_result: got %0d want 0", bus.result); end
    n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.result_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_terr: got %b want 0", bus.timeout_err); end
    #10 rst_n = 1'b1;
    cyc(3);
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL idle_signal: got %b want 0", bus.lenet_signal); end
  endtask

  task automatic test_manual_capture();
    bus.trigger = 1'b1; cyc(1);
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL trig_latency: got %b want 0", bus.lenet_signal); end
    bus.trigger = 1'b0; cyc(1);
    n_vec++; if (bus.lenet_signal !== 1'b1) begin n_err++; $display("FAIL arm_signal: got %b want 1", bus.lenet_signal); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL arm_busy: got %b want 1", bus.busy); end
    frame_pulse();
    n_vec++; if (bus.lenet_signal !== 1'b1) begin n_err++; $display("FAIL cap_signal: got %b want 1", bus.lenet_signal); end
    cyc(999);
    ready_pulse();
    n_vec++; if (bus.lenet_start !== 1'b1) begin n_err++; $display("FAIL start_pulse: got %b want 1", bus.lenet_start); end
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL signal_drop: got %b want 0", bus.lenet_signal); end
    done_pulse(4'd3);  // lands in the start cycle, must be ignored
    n_vec++; if (bus.lenet_start !== 1'b0) begin n_err++; $display("FAIL start_width: got %b want 0", bus.lenet_start); end
    n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL early_done: got %b want 0", bus.result_valid); end
    done_pulse(4'd7);
    n_vec++; if (bus.result !== 4'd7) begin n_err++; $display("FAIL result7: got %0d want 7", bus.result); end
    n_vec++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL valid7: got %b want 1", bus.result_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL hold_busy: got %b want 0", bus.busy); end
    hold_frames();
    cyc(5);
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL idle_after_hold: got %b want 0", bus.lenet_signal); end
  endtask

  task automatic test_auto();
    s0 = start_cnt;
    bus.auto_en = 1'b1; cyc(1);
    n_vec++; if (bus.lenet_signal !== 1'b1) begin n_err++; $display("FAIL auto_arm: got %b want 1", bus.lenet_signal); end
    for (int i = 0; i < 3; i++) begin
      frame_pulse(); cyc(2);
      ready_pulse();
      n_vec++; if (bus.lenet_start !== 1'b1) begin n_err++; $display("FAIL auto_start%0d: got %b want 1", i, bus.lenet_start); end
      cyc(1);
      done_pulse(4'(i + 1));
      n_vec++; if (bus.result !== 4'(i + 1)) begin n_err++; $display("FAIL auto_result%0d: got %0d want %0d", i, bus.result, i + 1); end
      if (i == 2) bus.auto_en = 1'b0;
      for (int f = 1; f <= 4; f++) begin
        frame_pulse();
        n_vec++;
        if (bus.lenet_signal !== ((f == 4) && (i < 2))) begin
          n_err++; $display("FAIL auto_rearm%0d_f%0d: got %b want %b", i, f, bus.lenet_signal, (f == 4) && (i < 2));
        end
        cyc(3);
      end
    end
    n_vec++; if (start_cnt - s0 !== 3) begin n_err++; $display("FAIL auto_count: got %0d want 3", start_cnt - s0); end
  endtask

  task automatic test_retry();
    trig_edge();
    s0 = start_cnt;
    frame_pulse(); cyc(5);
    frame_pulse();
    n_vec++; if (bus.lenet_signal !== 1'b1) begin n_err++; $display("FAIL retry1_signal: got %b want 1", bus.lenet_signal); end
    n_vec++; if (bus.lenet_start !== 1'b0) begin n_err++; $display("FAIL retry1_start: got %b want 0", bus.lenet_start); end
    cyc(5);
    frame_pulse();
    n_vec++; if (bus.lenet_signal !== 1'b1) begin n_err++; $display("FAIL retry2_signal: got %b want 1", bus.lenet_signal); end
    cyc(5);
    bus.frame_start = 1'b1; bus.data_ready = 1'b1; cyc(1);
    bus.frame_start = 1'b0; bus.data_ready = 1'b0;
    n_vec++; if (bus.lenet_start !== 1'b1) begin n_err++; $display("FAIL ready_wins: got %b want 1", bus.lenet_start); end
    cyc(3);
    n_vec++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL retry_starts: got %0d want 1", start_cnt - s0); end
    done_pulse(4'd2);
    n_vec++; if (bus.result !== 4'd2) begin n_err++; $display("FAIL retry_result: got %0d want 2", bus.result); end
    hold_frames();
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL retry_idle: got %b want 0", bus.lenet_signal); end
  endtask

  task automatic test_pending();
    s0 = start_cnt;
    trig_edge();
    frame_pulse(); cyc(2);
    ready_pulse(); cyc(1);
    repeat (3) trig_edge();
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL infer_busy: got %b want 1", bus.busy); end
    done_pulse(4'd5);
    n_vec++; if (bus.result !== 4'd5) begin n_err++; $display("FAIL pend_result5: got %0d want 5", bus.result); end
    hold_frames();
    n_vec++; if (bus.lenet_signal !== 1'b1) begin n_err++; $display("FAIL pend_rearm: got %b want 1", bus.lenet_signal); end
    frame_pulse(); cyc(2);
    ready_pulse(); cyc(1);
    done_pulse(4'd9);
    n_vec++; if (bus.result !== 4'd9) begin n_err++; $display("FAIL pend_result9: got %0d want 9", bus.result); end
    hold_frames();
    cyc(10);
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL pend_idle: got %b want 0", bus.lenet_signal); end
    n_vec++; if (start_cnt - s0 !== 2) begin n_err++; $display("FAIL pend_starts: got %0d want 2", start_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    trig_edge();
    frame_pulse(); cyc(3);
    s0 = start_cnt;
    #5 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL async_signal: got %b want 0", bus.lenet_signal); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.result !== 4'd0) begin n_err++; $display("FAIL async_result: got %0d want 0", bus.result); end
    n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", bus.result_valid); end
    cyc(3);
    rst_n = 1'b1;
    ready_pulse();
    n_vec++; if (bus.lenet_start !== 1'b0) begin n_err++; $display("FAIL post_rst_start: got %b want 0", bus.lenet_start); end
    cyc(3);
    n_vec++; if (bus.lenet_signal !== 1'b0) begin n_err++; $display("FAIL post_rst_signal: got %b want 0", bus.lenet_signal); end
    n_vec++; if (start_cnt - s0 !== 0) begin n_err++; $display("FAIL post_rst_starts: got %0d want 0", start_cnt - s0); end
  endtask

`ifdef LENET_TIMEOUT_EN
  task automatic test_timeout();
    trig_edge();
    frame_pulse(); cyc(2);
    ready_pulse(); cyc(1);
    done_pulse(4'd4);
    hold_frames();
    trig_edge();
    frame_pulse(); cyc(2);
    ready_pulse();
    cyc(99);
    n_vec++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL terr_early: got %b want 0", bus.timeout_err); end
    cyc(1);
    n_vec++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL terr_set: got %b want 1", bus.timeout_err); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL terr_hold: got %b want 0", bus.busy); end
    n_vec++; if (bus.result !== 4'd4) begin n_err++; $display("FAIL terr_result: got %0d want 4", bus.result); end
    hold_frames();
    n_vec++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL terr_sticky: got %b want 1", bus.timeout_err); end
  endtask
`else
  task automatic test_timeout();
    n_vec++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL terr_tied: got %b want 0", bus.timeout_err); end
  endtask
`endif

  initial begin
    bus.frame_start = 1'b0;
    bus.data_ready  = 1'b0;
    bus.trigger     = 1'b0;
    bus.auto_en     = 1'b0;
    bus.lenet_done  = 1'b0;
    bus.lenet_digit = 4'd0;
    test_reset();
    test_manual_capture();
    test_auto();
    test_retry();
    test_pending();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
